// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared FSM encoding, error bit indices and parameter legality check for instr_fetch_mem
package instr_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE = 1;
  localparam int MAX_WAIT_STATES = 15;
  function automatic bit params_ok(int ws, int wb, int depth);
    return ws >= 0 && ws <= MAX_WAIT_STATES && wb >= 1 && wb <= 8 && (wb & (wb - 1)) == 0 &&
           depth >= wb && depth % wb == 0;
  endfunction
endpackage

// File: rtl/imem_byte_array.sv
// imem_byte_array: byte storage with one byte write port and a little-endian word read port
// Ports: clk; we/waddr/wdata write one byte on the rising edge;
//        raddr/rdata combinational word read, rdata[8k+7:8k] = mem[raddr+k], bytes past the end read 0.
module imem_byte_array #(
  parameter int DEPTH_BYTES = 512,
  parameter int WORD_BYTES = 4,
  localparam int IW = $clog2(DEPTH_BYTES)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IW-1:0]           waddr,
  input  logic [7:0]              wdata,
  input  logic [IW-1:0]           raddr,
  output logic [8*WORD_BYTES-1:0] rdata
);
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb begin
    rdata = '0;
    for (int k = 0; k < WORD_BYTES; k++)
      rdata[8*k +: 8] = ({1'b0, raddr} + (IW+1)'(k)) < (IW+1)'(DEPTH_BYTES) ? mem[raddr + IW'(k)] : 8'h00;
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: synchronous instruction memory with valid/ready fetch, wait states, error checks and byte preload
// Ports: clk, rst (async, active high);
//        req_valid/req_ready/req_addr fetch request; rsp_valid/rsp_ready/rsp_data/rsp_err registered response
//        (rsp_err bit0 misaligned, bit1 out of range); load_en/load_addr/load_data byte preload, any state.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH_BYTES = 512,
  parameter int WORD_BYTES = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic [1:0]              rsp_err,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [7:0]              load_data
);
  localparam int IW = $clog2(DEPTH_BYTES);
  if (!params_ok(WAIT_STATES, WORD_BYTES, DEPTH_BYTES)) begin : g_bad_params
    $error("instr_fetch_mem: illegal WAIT_STATES/WORD_BYTES/DEPTH_BYTES");
  end
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, cap_addr;
  logic accept, capture, we;
  logic [1:0] err;
  logic [8*WORD_BYTES-1:0] rd_data;
  imem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES), .WORD_BYTES(WORD_BYTES)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(load_addr[IW-1:0]),
    .wdata(load_data),
    .raddr(cap_addr[IW-1:0]),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = state == IDLE ? (accept ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == '0 ? RESP : WAIT) :
              state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  // req_ready is registered so it stays low while rst is high; it also gates acceptance
  // so nothing is taken in the first cycle after reset release.
  always_comb begin
    accept = state == IDLE && req_ready && req_valid;
    capture = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == '0);
    cap_addr = state == IDLE ? req_addr : addr_q;
    err = '0;
    err[ERR_MISALIGN] = (cap_addr & ADDR_WIDTH'(WORD_BYTES - 1)) != '0;
    err[ERR_RANGE] = cap_addr > ADDR_WIDTH'(DEPTH_BYTES - WORD_BYTES);
    cnt_d = accept && WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : state == WAIT && cnt != '0 ? cnt - 4'd1 : cnt;
    we = load_en && load_addr < ADDR_WIDTH'(DEPTH_BYTES);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      addr_q <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= '0;
    end else begin
      cnt <= cnt_d;
      req_ready <= state_d == IDLE;
      rsp_valid <= state_d == RESP;
      if (accept) addr_q <= req_addr;
      if (capture) begin
        rsp_data <= |err ? '0 : rd_data;
        rsp_err <= err;
      end
    end
endmodule
